// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and sizing helpers for the instruction prefetch unit.
package ifetch_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h80020000;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched {pc, instr} entries; flush beats push and pop.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = ptr_w(DEPTH),
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  din_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_push = push_i & (cnt_q != FULL);
    assign do_pop  = pop_i & (cnt_q != '0);

    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + PW'(do_push);
        rd_d  = flush_i ? '0 : rd_q + PW'(do_pop);
        cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push && !flush_i) mem_q[wr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: sequential instruction prefetcher feeding the core, with redirect
// flush and dropping of responses that belong to the abandoned fetch stream.
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter word_t PC_INIT = PC_INIT_DEFAULT,
    parameter int    DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    localparam int          CW  = cnt_w(DEPTH);
    localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

    word_t         fetch_q, fetch_d, resp_q, resp_d, redir_pc;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
    logic          fire, rv, push, pop;
    fetch_entry_t  head;

    assign redir_pc    = {redirect_pc[31:2], 2'b00};
    assign imem_req    = !reset & !redirect_valid & (({1'b0, count} + {1'b0, out_q}) < CAP) & (drop_q == '0);
    assign imem_addr   = fetch_q;
    assign fire        = imem_req & imem_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rv          = imem_rvalid & (out_q != '0);
    assign push        = rv & (drop_q == '0) & !redirect_valid;
    assign instr_valid = count != '0;
    assign pop         = instr_valid & instr_ready;
    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;

    always_comb begin
        out_d   = out_q + CW'(fire) - CW'(rv);
        drop_d  = redirect_valid ? out_q - CW'(rv) : drop_q - CW'(rv & (drop_q != '0));
        fetch_d = redirect_valid ? redir_pc : fetch_q + (fire ? 32'd4 : 32'd0);
        resp_d  = redirect_valid ? redir_pc : resp_q + (push ? 32'd4 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_q <= PC_INIT;
            resp_q  <= PC_INIT;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            fetch_q <= fetch_d;
            resp_q  <= resp_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   ('{pc: resp_q, instr: imem_rdata}),
        .head_o  (head),
        .count_o (count)
    );

    a_cap: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, count} + {1'b0, out_q}) <= CAP);
    a_drop: assert property (@(posedge clk) disable iff (reset) drop_q <= out_q);

endmodule
